// File: rtl/regfile_mp.sv
// regfile_mp: multi-port integer register file with a per-register busy scoreboard.
//
// Purpose:
//   NRD combinational read ports and NWR synchronous write ports over DEPTH
//   registers of WIDTH bits. Register 0 always reads zero and is never busy.
//   A busy bit per register is set at issue (sb_set) and cleared by writeback
//   (any accepted write). sb_flush clears every busy bit. busy_cnt tracks how
//   many registers are currently busy. With BYPASS=1 a write in flight this
//   cycle is forwarded to matching reads, and the matching read reports not busy.
//
// Ports:
//   clk       clock, all state updates on posedge
//   rst       asynchronous, active-low reset
//   rd_addr   NRD packed read addresses (port i = [i*AW +: AW])
//   rd_dout   NRD packed read data (port i = [i*WIDTH +: WIDTH])
//   rd_busy   busy bit of the register addressed by each read port
//   we        per-port write enable
//   wr_addr   NWR packed write addresses
//   wr_din    NWR packed write data
//   sb_set    mark sb_addr busy
//   sb_addr   register to mark busy
//   sb_flush  clear all busy bits
//   busy_cnt  number of busy registers
module regfile_mp #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 32,
  parameter int NRD    = 2,
  parameter int NWR    = 1,
  parameter int BYPASS = 1,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NRD*AW-1:0]    rd_addr,
  output logic [NRD*WIDTH-1:0] rd_dout,
  output logic [NRD-1:0]       rd_busy,
  input  logic [NWR-1:0]       we,
  input  logic [NWR*AW-1:0]    wr_addr,
  input  logic [NWR*WIDTH-1:0] wr_din,
  input  logic                 sb_set,
  input  logic [AW-1:0]        sb_addr,
  input  logic                 sb_flush,
  output logic [AW:0]          busy_cnt
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] busy_nxt;
  logic [DEPTH-1:0] clr_mask;
  logic [AW:0]      cnt_nxt;
  logic [AW:0]      n_clr;
  logic             set_hit;

  // Register array. Ports are visited in ascending order so the highest
  // index wins when several ports target the same register. Address 0 is
  // never written, so it stays zero after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      for (int j = 0; j < NWR; j++) begin
        if (we[j] && (wr_addr[j*AW +: AW] != '0)) begin
          mem[wr_addr[j*AW +: AW]] <= wr_din[j*WIDTH +: WIDTH];
        end
      end
    end
  end

  // One bit per register that retires this cycle (accepted nonzero write).
  always_comb begin
    clr_mask = '0;
    for (int j = 0; j < NWR; j++) begin
      if (we[j] && (wr_addr[j*AW +: AW] != '0)) begin
        clr_mask[wr_addr[j*AW +: AW]] = 1'b1;
      end
    end
  end

  // Scoreboard next state. A set to a register that retires in the same
  // cycle keeps it busy (new producer), so that register is not counted as
  // cleared. The count is updated incrementally rather than re-popcounted.
  always_comb begin
    busy_nxt = busy;
    cnt_nxt  = busy_cnt;
    n_clr    = '0;
    set_hit  = sb_set && (sb_addr != '0);
    if (sb_flush) begin
      busy_nxt = '0;
      cnt_nxt  = '0;
    end else begin
      busy_nxt = busy & ~clr_mask;
      if (set_hit) begin
        busy_nxt[sb_addr] = 1'b1;
      end
      for (int k = 0; k < DEPTH; k++) begin
        if (busy[k] && clr_mask[k] && !(set_hit && (sb_addr == AW'(k)))) begin
          n_clr = n_clr + (AW+1)'(1);
        end
      end
      cnt_nxt = busy_cnt - n_clr + (AW+1)'(set_hit && !busy[sb_addr]);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      busy     <= busy_nxt;
      busy_cnt <= cnt_nxt;
    end
  end

  // Read ports. Bypass overrides stored data (highest matching write port
  // wins) and hides the busy bit since the value is already available.
  // Everything reads zero while reset is held, even with writes pending.
  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0]    ra;
    logic [WIDTH-1:0] rdata;
    logic             rbusy;

    always_comb begin
      ra    = rd_addr[i*AW +: AW];
      rdata = mem[ra];
      rbusy = busy[ra];
      if (BYPASS != 0) begin
        for (int j = 0; j < NWR; j++) begin
          if (we[j] && (wr_addr[j*AW +: AW] == ra) && (ra != '0)) begin
            rdata = wr_din[j*WIDTH +: WIDTH];
            rbusy = 1'b0;
          end
        end
      end
      if ((ra == '0) || !rst) begin
        rdata = '0;
      end
      if (!rst) begin
        rbusy = 1'b0;
      end
    end

    assign rd_dout[i*WIDTH +: WIDTH] = rdata;
    assign rd_busy[i]                = rbusy;
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port integer register file for the RV32I core: NRD asynchronous read ports, NWR synchronous write ports, optional write-to-read bypass.
- Adds a per-register busy scoreboard for pipelined issue. Decode sets a register busy; writeback clears it. Hazard logic reads the busy bits alongside the operands.
- Register 0 is hardwired to zero and is never busy.

Parameters:
WIDTH, 32, data width in bits
DEPTH, 32, number of registers (power of 2, >=2); AW = $clog2(DEPTH)
NRD, 2, number of read ports (>=1)
NWR, 1, number of write ports (>=1)
BYPASS, 1, 1 = same-cycle write data forwarded to reads; 0 = reads see stored value only

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  reset, asynchronous, active-low
rd_addr  in  NRD*AW  read addresses; port i = bits [i*AW +: AW]
rd_dout  out  NRD*WIDTH  read data; port i = bits [i*WIDTH +: WIDTH]
rd_busy  out  NRD  busy bit of the register addressed by each read port
we  in  NWR  write enable per write port
wr_addr  in  NWR*AW  write addresses, packed as for rd_addr
wr_din  in  NWR*WIDTH  write data, packed as for rd_dout
sb_set  in  1  mark register sb_addr busy (instruction issued)
sb_addr  in  AW  destination register to mark busy
sb_flush  in  1  clear all busy bits (pipeline flush)
busy_cnt  out  AW+1  number of busy registers

Behaviour:
- Reset (rst=0, asynchronous, at any time including mid-operation):
  - all registers and all busy bits clear to 0; busy_cnt=0.
  - rd_dout shows 0 for every address while rst=0; rd_busy=0.
  - Writes, sb_set and sb_flush are ignored while rst=0.
- Write, posedge clk: for each port j with we[j]=1 and wr_addr[j]!=0, mem[wr_addr[j]] <= wr_din[j].
  - Writes to address 0 are discarded.
  - Two or more ports writing the same address: the highest port index wins.
- Read is combinational.
  - rd_dout[i] = 0 if rd_addr[i]==0, else mem[rd_addr[i]].
  - If BYPASS=1 and some port j has we[j]=1 and wr_addr[j]==rd_addr[i]!=0, rd_dout[i] = wr_din of the highest such j.
- Busy bit update, posedge clk, evaluated in this order:
  1. sb_flush=1: all bits go to 0 and sb_set is ignored that cycle. Writes still update the data.
  2. Otherwise, each accepted write (we[j]=1, wr_addr[j]!=0) clears busy[wr_addr[j]].
  3. Then sb_set=1 with sb_addr!=0 sets busy[sb_addr]. Set wins over a clear to the same address in the same cycle, because a new producer overrides the retiring one.
  - sb_set to address 0 is ignored; busy[0] is constant 0.
  - Setting an already-busy bit leaves it 1.
- rd_busy[i] = busy[rd_addr[i]].
  - If BYPASS=1 and a write to that nonzero address occurs in the same cycle, rd_busy[i]=0, because the data is on rd_dout via bypass.
  - A same-cycle sb_set is not visible on rd_busy until the next cycle.
- busy_cnt is a registered popcount of the busy vector after the update, maintained incrementally.
  - Next value = current − (number of distinct busy bits cleared) + (1 if a previously clear bit is set).
  - Range 0..DEPTH−1. It equals the popcount at all times; this is checked by assertion in the bench.
- No read latency; write latency is 1 cycle (data visible on the next cycle with BYPASS=0, same cycle with BYPASS=1).

Test Plan:
- Reset then read: rst=0→1; read every address on all ports → rd_dout=0, rd_busy=0, busy_cnt=0.
- Basic write and x0 guard, BYPASS=0: write 0xDEADBEEF to r5, then 0x12345678 to r0.
  - Next cycle rd_addr0=5 → 0xDEADBEEF; rd_addr1=0 → 0.
- Bypass and port priority, NWR=2, BYPASS=1: same cycle, port0 writes r7=0x11, port1 writes r7=0x22, rd_addr0=7.
  - Same cycle rd_dout0=0x22; next cycle stored value is 0x22.
- Scoreboard: sb_set r3 → next cycle rd_busy for r3=1, busy_cnt=1.
  - Write r3=0xAA → during that cycle rd_busy=0 and rd_dout=0xAA (BYPASS=1); next cycle busy_cnt=0.
- Set/clear collision and flush:
  - r4 busy; sb_set r4 and write r4 in the same cycle → r4 stays busy, busy_cnt unchanged.
  - Set r1, r2, r9, then sb_flush → busy_cnt=0, all rd_busy=0.
- Asynchronous reset mid-operation: with r5=0xDEADBEEF and r3 busy, pull rst low between clock edges → rd_dout=0 and busy_cnt=0 immediately, without waiting for a clock edge.
